daco_host_scheduler: RTL and testbench



---
 rtl/daco_pkg.sv | 29 ++
 rtl/daco_host_scheduler_if.sv | 40 ++++
 rtl/daco_sync_fifo.sv | 45 ++++
 rtl/daco_host_scheduler.sv | 145 ++++++++++++++
 tb/tb_daco_host_scheduler.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/daco_pkg.sv
// Shared types and constants for the DaCO host scheduler.
// Packet layout: MSB is the valid flag, low nibble holds the mesh destination.
package daco_pkg;

  localparam int PACKET_W      = 64;
  localparam int PKT_VALID_BIT = PACKET_W - 1;
  localparam int DST_FIELD_W   = 2;
  localparam int DST_X_LSB     = 0;
  localparam int DST_Y_LSB     = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP
  } state_t;

  function automatic logic [DST_FIELD_W-1:0] pkt_dst_x(
    input logic [PACKET_W-1:0] p
  );
    return p[DST_X_LSB +: DST_FIELD_W];
  endfunction

  function automatic logic [DST_FIELD_W-1:0] pkt_dst_y(
    input logic [PACKET_W-1:0] p
  );
    return p[DST_Y_LSB +: DST_FIELD_W];
  endfunction

endpackage

// File: rtl/daco_host_scheduler_if.sv
// Host and overlay packet signals of the DaCO scheduler.
// master = scheduler side, slave = host/overlay side.
interface daco_host_scheduler_if;
  import daco_pkg::*;

  logic [PACKET_W-1:0] host_in_pkt;
  logic                host_in_valid;
  logic                host_in_ready;
  logic [PACKET_W-1:0] host_out_pkt;
  logic                host_out_valid;
  logic                host_out_ready;
  logic [PACKET_W-1:0] controller2daco;
  logic [PACKET_W-1:0] daco2controller;
  logic                ack2controller;

  modport master (
    input  host_in_pkt,
    input  host_in_valid,
    output host_in_ready,
    output host_out_pkt,
    output host_out_valid,
    input  host_out_ready,
    output controller2daco,
    input  daco2controller,
    input  ack2controller
  );

  modport slave (
    output host_in_pkt,
    output host_in_valid,
    input  host_in_ready,
    input  host_out_pkt,
    input  host_out_valid,
    output host_out_ready,
    input  controller2daco,
    output daco2controller,
    output ack2controller
  );

endinterface

// File: rtl/daco_sync_fifo.sv
// Single-clock FIFO with show-ahead head output.
// Pointers carry one extra bit to tell full from empty.
module daco_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wp;
  logic [AW:0]      r_rp;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wp == r_rp);
  assign o_full  = (r_wp[AW] != r_rp[AW]) &&
                   (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/daco_host_scheduler.sv
// Issues host packets to the DaCO overlay with ack/timeout/retry,
// and buffers overlay responses for the host.
module daco_host_scheduler
  import daco_pkg::*;
#(
  parameter int ISSUE_DEPTH = 8,
  parameter int RSP_DEPTH   = 8,
  parameter int TIMEOUT     = 16,
  parameter int MAX_RETRY   = 3,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  daco_host_scheduler_if.master bus,
  input  logic                  enable,
  input  logic                  err_clear,
  output logic                  busy,
  output logic                  err_sticky,
  output logic [CNT_W-1:0]      drop_count,
  output logic [CNT_W-1:0]      ovf_count
);
  localparam int TW = $clog2(TIMEOUT);
  localparam int RW = $clog2(MAX_RETRY + 2);

  state_t              r_state, w_state_n;
  logic [PACKET_W-1:0] r_cur;
  logic [TW-1:0]       r_tcnt, w_tcnt_n;
  logic [RW-1:0]       r_retry, w_retry_n;
  logic                w_load, w_drop, w_ovf;
  logic                w_iss_full, w_iss_empty;
  logic [PACKET_W-1:0] w_iss_head;
  logic                w_rsp_full, w_rsp_empty;
  logic                w_rsp_in;
  logic                r_sticky;
  logic [CNT_W-1:0]    r_drop, r_ovf;

  daco_sync_fifo #(.WIDTH(PACKET_W), .DEPTH(ISSUE_DEPTH)) u_iss (
    .clk     (clk),
    .rst     (rst),
    .i_push  (bus.host_in_valid),
    .i_pop   (w_load),
    .i_data  (bus.host_in_pkt),
    .o_head  (w_iss_head),
    .o_full  (w_iss_full),
    .o_empty (w_iss_empty)
  );

  assign w_rsp_in = bus.daco2controller[PKT_VALID_BIT];
  assign w_ovf    = w_rsp_in && w_rsp_full;

  daco_sync_fifo #(.WIDTH(PACKET_W), .DEPTH(RSP_DEPTH)) u_rsp (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_rsp_in),
    .i_pop   (bus.host_out_ready),
    .i_data  (bus.daco2controller),
    .o_head  (bus.host_out_pkt),
    .o_full  (w_rsp_full),
    .o_empty (w_rsp_empty)
  );

  assign bus.host_in_ready   = !w_iss_full;
  assign bus.host_out_valid  = !w_rsp_empty;
  assign bus.controller2daco = (r_state == ST_SEND) ? r_cur : '0;
  assign busy       = (r_state != ST_IDLE) || !w_iss_empty;
  assign err_sticky = r_sticky;
  assign drop_count = r_drop;
  assign ovf_count  = r_ovf;

  always_comb begin
    w_state_n = r_state;
    w_tcnt_n  = r_tcnt;
    w_retry_n = r_retry;
    w_load    = 1'b0;
    w_drop    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (enable && !w_iss_empty) begin
          w_load    = 1'b1;
          w_state_n = ST_SEND;
          w_tcnt_n  = '0;
          w_retry_n = '0;
        end
      end
      ST_SEND: begin
        if (bus.ack2controller) begin
          if (enable && !w_iss_empty) begin
            w_load    = 1'b1;
            w_tcnt_n  = '0;
            w_retry_n = '0;
          end else begin
            w_state_n = ST_IDLE;
          end
        end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
          if (r_retry == RW'(MAX_RETRY)) begin
            w_drop    = 1'b1;
            w_state_n = ST_IDLE;
          end else begin
            w_state_n = ST_GAP;
            w_retry_n = r_retry + 1'b1;
          end
        end else begin
          w_tcnt_n = r_tcnt + 1'b1;
        end
      end
      ST_GAP: begin
        w_state_n = ST_SEND;
        w_tcnt_n  = '0;
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  // An event in the clear cycle survives as a count of one.
  function automatic logic [CNT_W-1:0] f_cnt(
    input logic [CNT_W-1:0] c,
    input logic             clr,
    input logic             ev
  );
    if (clr) return CNT_W'(ev);
    if (ev && (c != '1)) return c + 1'b1;
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cur    <= '0;
      r_tcnt   <= '0;
      r_retry  <= '0;
      r_sticky <= 1'b0;
      r_drop   <= '0;
      r_ovf    <= '0;
    end else begin
      r_state  <= w_state_n;
      r_tcnt   <= w_tcnt_n;
      r_retry  <= w_retry_n;
      if (w_load) r_cur <= w_iss_head;
      r_sticky <= w_drop || (r_sticky && !err_clear);
      r_drop   <= f_cnt(r_drop, err_clear, w_drop);
      r_ovf    <= f_cnt(r_ovf, err_clear, w_ovf);
    end
  end

endmodule

// File: tb/tb_daco_host_scheduler.sv
// Bench for daco_host_scheduler: directed scenarios plus random traffic
// checked every cycle against a queue-based packet-lifetime model.
module tb_daco_host_scheduler;
  import daco_pkg::*;

  localparam int ID   = 8;
  localparam int RD   = 8;
  localparam int TO   = 16;
  localparam int MR   = 3;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
  // Packet lifetime: attempts of TO cycles, each followed by a 1-cycle gap
  // except the last one.
  localparam int LIFE = (1 + MR) * (TO + 1) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          err_clear = 1'b0;
  logic          busy;
  logic          err_sticky;
  logic [CW-1:0] drop_count;
  logic [CW-1:0] ovf_count;

  daco_host_scheduler_if bus ();

  daco_host_scheduler #(
    .ISSUE_DEPTH (ID),
    .RSP_DEPTH   (RD),
    .TIMEOUT     (TO),
    .MAX_RETRY   (MR),
    .CNT_W       (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .enable     (enable),
    .err_clear  (err_clear),
    .busy       (busy),
    .err_sticky (err_sticky),
    .drop_count (drop_count),
    .ovf_count  (ovf_count)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  logic [63:0] iq[$];
  logic [63:0] rq[$];
  logic [63:0] acc_q[$];
  bit          m_have;
  logic [63:0] m_pkt;
  int          m_age;
  bit          m_sticky;
  int          m_drop;
  int          m_ovf;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic bit in_gap(input int age);
    return (age % (TO + 1)) == TO;
  endfunction

  task automatic model_step();
    bit drop_ev = 0;
    bit ovf_ev  = 0;
    bit push_i;
    bit pop_r;
    if (rst) begin
      iq.delete(); rq.delete();
      m_have = 0; m_age = 0;
      m_sticky = 0; m_drop = 0; m_ovf = 0;
      return;
    end
    push_i = bus.host_in_valid && (iq.size() < ID);
    if (!m_have) begin
      if (enable && iq.size() > 0) begin
        m_pkt = iq.pop_front(); m_have = 1; m_age = 0;
      end
    end else if (in_gap(m_age)) begin
      m_age++;
    end else if (bus.ack2controller) begin
      if (enable && iq.size() > 0) begin
        m_pkt = iq.pop_front(); m_age = 0;
      end else begin
        m_have = 0;
      end
    end else if (m_age == LIFE - 1) begin
      m_have = 0; drop_ev = 1;
    end else begin
      m_age++;
    end
    if (push_i) begin
      iq.push_back(bus.host_in_pkt);
      acc_q.push_back(bus.host_in_pkt);
    end
    pop_r = bus.host_out_ready && (rq.size() > 0);
    ovf_ev = bus.daco2controller[63] && (rq.size() == RD);
    if (pop_r) rq.delete(0);
    if (bus.daco2controller[63] && !ovf_ev) rq.push_back(bus.daco2controller);
    m_sticky = drop_ev ? 1'b1 : (err_clear ? 1'b0 : m_sticky);
    if (err_clear) m_drop = int'(drop_ev);
    else if (drop_ev && m_drop < CMAX) m_drop++;
    if (err_clear) m_ovf = int'(ovf_ev);
    else if (ovf_ev && m_ovf < CMAX) m_ovf++;
  endtask

  task automatic compare();
    logic [63:0] e_c2d;
    e_c2d = (m_have && !in_gap(m_age)) ? m_pkt : 64'd0;
    chk("controller2daco", bus.controller2daco, e_c2d);
    chk("host_in_ready", bus.host_in_ready, iq.size() < ID);
    chk("host_out_valid", bus.host_out_valid, rq.size() > 0);
    if (rq.size() > 0) chk("host_out_pkt", bus.host_out_pkt, rq[0]);
    chk("busy", busy, m_have || iq.size() > 0);
    chk("err_sticky", err_sticky, m_sticky);
    chk("drop_count", drop_count, m_drop);
    chk("ovf_count", ovf_count, m_ovf);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  int ackp[4] = '{70, 5, 0, 40};
  int horp[4] = '{50, 10, 0, 80};

  initial begin
    int          nz;
    int          guard;
    logic [63:0] tmp;
    bus.host_in_pkt     = '0;
    bus.host_in_valid   = 1'b0;
    bus.host_out_ready  = 1'b0;
    bus.daco2controller = '0;
    bus.ack2controller  = 1'b0;
    cycle(); cycle();
    rst = 1'b0;
    cycle();
    chk("rst_c2d", bus.controller2daco, 64'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_hir", bus.host_in_ready, 1'b1);
    chk("rst_hov", bus.host_out_valid, 1'b0);
    chk("rst_drop", drop_count, 0);

    // single packet, ack on third SEND cycle
    enable = 1'b1;
    bus.host_in_valid = 1'b1;
    bus.host_in_pkt = 64'h8000_0000_0000_00A5;
    cycle();
    bus.host_in_valid = 1'b0;
    chk("t1_c2d_t1", bus.controller2daco, 64'd0);
    cycle();
    chk("t1_c2d_s1", bus.controller2daco, 64'h8000_0000_0000_00A5);
    cycle();
    chk("t1_c2d_s2", bus.controller2daco, 64'h8000_0000_0000_00A5);
    cycle();
    chk("t1_c2d_s3", bus.controller2daco, 64'h8000_0000_0000_00A5);
    bus.ack2controller = 1'b1;
    cycle();
    bus.ack2controller = 1'b0;
    chk("t1_c2d_end", bus.controller2daco, 64'd0);
    chk("t1_busy_end", busy, 1'b0);
    chk("t1_drop", drop_count, 0);

    // fill the issue path with ack low, then drain back-to-back
    acc_q.delete();
    for (int i = 0; i < 10; i++) begin
      bus.host_in_valid = 1'b1;
      bus.host_in_pkt = 64'h8000_0000_0000_0100 + 64'(i);
      cycle();
    end
    bus.host_in_valid = 1'b0;
    chk("t2_hir_full", bus.host_in_ready, 1'b0);
    chk("t2_accepted", acc_q.size(), 1 + ID);
    bus.ack2controller = 1'b1;
    for (int k = 0; k < 1 + ID; k++) begin
      chk("t2_order", bus.controller2daco, 64'h8000_0000_0000_0100 + 64'(k));
      cycle();
    end
    chk("t2_c2d_end", bus.controller2daco, 64'd0);
    bus.ack2controller = 1'b0;

    // never acked: four windows then drop
    bus.host_in_valid = 1'b1;
    bus.host_in_pkt = 64'h8000_0000_0000_0ABC;
    cycle();
    bus.host_in_valid = 1'b0;
    nz = 0;
    for (int k = 0; k < 80; k++) begin
      cycle();
      if (bus.controller2daco != 64'd0) nz++;
    end
    chk("t3_send_cycles", nz, 64);
    chk("t3_c2d_end", bus.controller2daco, 64'd0);
    chk("t3_sticky", err_sticky, 1'b1);
    chk("t3_drop", drop_count, 1);

    // response overflow and ordered drain
    err_clear = 1'b1;
    cycle();
    err_clear = 1'b0;
    chk("t4_clr_drop", drop_count, 0);
    chk("t4_clr_sticky", err_sticky, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      bus.daco2controller = 64'h8000_0000_0000_0000 | 64'(i);
      cycle();
    end
    bus.daco2controller = '0;
    chk("t4_hov", bus.host_out_valid, 1'b1);
    chk("t4_ovf", ovf_count, 1);
    bus.host_out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("t4_drain", bus.host_out_pkt, 64'h8000_0000_0000_0000 | 64'(i));
      cycle();
    end
    bus.host_out_ready = 1'b0;
    chk("t4_hov_empty", bus.host_out_valid, 1'b0);

    // reset in the fifth SEND cycle with three queued
    for (int i = 0; i < 4; i++) begin
      bus.host_in_valid = 1'b1;
      bus.host_in_pkt = 64'h8000_0000_0000_0200 + 64'(i);
      bus.daco2controller = (i == 0) ? 64'h8000_0000_0000_0077 : 64'd0;
      cycle();
    end
    bus.host_in_valid = 1'b0;
    bus.daco2controller = '0;
    guard = 0;
    while (!(m_have && m_age == 4) && guard < 20) begin
      cycle();
      guard++;
    end
    chk("t5_wait", guard < 20, 1'b1);
    chk("t5_queued", iq.size(), 3);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("t5_c2d", bus.controller2daco, 64'd0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_hov", bus.host_out_valid, 1'b0);
    chk("t5_drop", drop_count, 0);

    // enable low lets in-flight finish but blocks new pops
    for (int i = 0; i < 3; i++) begin
      bus.host_in_valid = 1'b1;
      bus.host_in_pkt = 64'h8000_0000_0000_0300 + 64'(i);
      cycle();
    end
    bus.host_in_valid = 1'b0;
    enable = 1'b0;
    bus.ack2controller = 1'b1;
    cycle();
    bus.ack2controller = 1'b0;
    chk("t6_c2d_idle", bus.controller2daco, 64'd0);
    chk("t6_busy", busy, 1'b1);
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("t6_hold", bus.controller2daco, 64'd0);
    end
    enable = 1'b1;
    cycle();
    enable = 1'b0;
    chk("t6_next", bus.controller2daco, 64'h8000_0000_0000_0301);
    guard = 0;
    while (!(m_have && m_age == LIFE - 1) && guard < 100) begin
      cycle();
      guard++;
    end
    chk("t6_wait", guard < 100, 1'b1);
    err_clear = 1'b1;
    cycle();
    err_clear = 1'b0;
    chk("t6_clr_drop", drop_count, 1);
    chk("t6_clr_sticky", err_sticky, 1'b1);

    // random traffic in four regimes
    for (int s = 0; s < 4; s++) begin
      for (int n = 0; n < 1500; n++) begin
        rst = (s != 2) && ($urandom_range(0, 599) == 0);
        enable = ($urandom_range(0, 9) != 0);
        err_clear = (s != 2) && ($urandom_range(0, 299) == 0);
        bus.host_in_valid = 1'($urandom_range(0, 1));
        bus.host_in_pkt = {$urandom, $urandom};
        bus.ack2controller = ($urandom_range(0, 99) < ackp[s]);
        bus.host_out_ready = ($urandom_range(0, 99) < horp[s]);
        tmp = {$urandom, $urandom};
        tmp[63] = ($urandom_range(0, 9) < 4);
        bus.daco2controller = tmp;
        cycle();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
